pll_phase_seq: RTL and testbench
================================

Name: pll_phase_seq

Overview:
Sequencer for ECP5 PLL dynamic phase adjustment and relock. It accepts phase-shift requests over a valid/ready handshake: target output, direction, step count and optional PLL reset. It then generates correctly timed phasesel/phasedir/phasestep/reset waveforms and waits for lock before reporting completion. It sits between control logic (e.g. a DDR/video capture calibration FSM) and the PLL wrapper's dynamic-phase and reset inputs.

Parameters:
SETUP_CYC, 2, cycles sel/dir are held stable before the first step pulse (>=1)
STEP_HIGH_CYC, 4, phasestep high width in cycles (>=1)
SETTLE_CYC, 8, phasestep low time after each pulse (>=1)
RESET_CYC, 16, pll_reset pulse width in cycles (>=1)
LOCK_TIMEOUT, 1000, max cycles in WAIT_LOCK before error (>=1)
CNT_W, 8, width of step count

Ports:
clk_i  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_sel  in  2  output index 0..3, same numbering as PLL clk_o
req_dir  in  1  phase direction, passed to pll_phasedir
req_steps  in  CNT_W  number of phase steps, 0 allowed
req_relock  in  1  pulse PLL reset and relock before stepping
done  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky lock-timeout flag
pll_phasesel  out  2  to PLL phasesel
pll_phasedir  out  1  to PLL phasedir
pll_phasestep  out  1  to PLL phasestep
pll_phaseloadreg  out  1  tied 0
pll_reset  out  1  to PLL reset (wrapper built with reset_en=1)
pll_locked  in  1  PLL lock, asynchronous to clk_i

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except req_ready=1; counters 0; err_timeout=0; lock synchronizer cleared.
- pll_locked passes through a 2-FF synchronizer (locked_s), so latency is 2 cycles. All lock decisions use locked_s.
- Accept: req_valid&&req_ready at rising edge T latches sel/dir/steps/relock into registers and clears err_timeout. The next state is entered in cycle T+1.
- Transitions out of IDLE on accept:
  - relock=1 goes to PLL_RST.
  - relock=0 with steps>0 goes to SETUP.
  - relock=0 with steps=0 goes to DONE.
- pll_phasesel and pll_phasedir are driven from latched registers while busy. They hold their last value in IDLE and change only on accept.
- PLL_RST: pll_reset=1 for exactly RESET_CYC cycles, then WAIT_LOCK.
- SETUP: held for SETUP_CYC cycles, then STEP_HI.
- STEP_HI: pll_phasestep=1 for STEP_HIGH_CYC cycles. The remaining-step counter decrements on exit. Next state is STEP_LO.
- STEP_LO: pll_phasestep=0 for SETTLE_CYC cycles. Next state is STEP_HI if remaining>0, else WAIT_LOCK.
- WAIT_LOCK: timer counts from 0.
  - locked_s=1 exits in the same cycle: to SETUP if remaining>0 (post-relock path), else to DONE.
  - If the timer reaches LOCK_TIMEOUT-1 with locked_s=0: set err_timeout, discard remaining steps, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- req_valid outside IDLE is ignored (req_ready=0). No queuing.
- The step counter is CNT_W bits with no wrap; req_steps=2^CNT_W-1 must execute fully.
- Timers are sized $clog2(max param)+1 and reload on each state entry.
- Reset mid-operation: pll_phasestep and pll_reset drop to 0 immediately (async). No done pulse is generated.

Test Plan:
- Reset: reset_n=0 while in STEP_HI -> pll_phasestep=0 at once; after release, req_ready=1, busy=0, err_timeout=0.
- Steps=3, sel=2, dir=1, relock=0, pll_locked=1, accept at T -> phasesel=2 and phasedir=1 from T+1; phasestep high in cycles T+3..T+6, T+15..T+18, T+27..T+30; done=1 at T+40 only; busy T+1..T+40.
- Relock=1, steps=1, pll_locked forced 0 during pll_reset and raised 5 cycles after it falls -> pll_reset high exactly 16 cycles; phasestep starts only after locked_s=1 plus SETUP_CYC; exactly 1 step pulse; done once; err_timeout=0.
- Relock=1, steps=4, pll_locked held 0 -> err_timeout=1 after 1000 WAIT_LOCK cycles; zero phasestep pulses; done pulses; next accepted request clears err_timeout.
- Steps=0, relock=0 -> no phasestep, no pll_reset; done at T+1.
- req_valid held high continuously with alternating requests -> each accepted only in IDLE, one done per accept; a second request presented while busy is not accepted until req_ready returns.

Source files
------------

// File: rtl/pll_phase_seq.sv
`timescale 1ns/1ps
// pll_phase_seq
// Sequencer for ECP5 PLL dynamic phase adjustment and relock. A request
// (output select, direction, step count, optional relock) is taken over a
// valid/ready handshake. The block then drives correctly timed
// phasesel/phasedir/phasestep/reset waveforms, waits for lock, and pulses
// done.
//
// Ports:
//   clk_i            system clock
//   reset_n          asynchronous active-low reset
//   req_valid        request valid
//   req_ready        high only while idle
//   req_sel          PLL output index 0..3
//   req_dir          phase direction
//   req_steps        number of phase steps (0 allowed)
//   req_relock       pulse PLL reset and relock before stepping
//   done             one-cycle completion pulse
//   busy             high whenever a request is in progress
//   err_timeout      sticky lock-timeout flag, cleared by the next accept
//   pll_phasesel     to PLL phasesel
//   pll_phasedir     to PLL phasedir
//   pll_phasestep    to PLL phasestep
//   pll_phaseloadreg to PLL phaseloadreg (tied low)
//   pll_reset        to PLL reset
//   pll_locked       PLL lock, asynchronous to clk_i
module pll_phase_seq #(
    parameter int SETUP_CYC     = 2,
    parameter int STEP_HIGH_CYC = 4,
    parameter int SETTLE_CYC    = 8,
    parameter int RESET_CYC     = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    input  logic             req_relock,
    output logic             done,
    output logic             busy,
    output logic             err_timeout,
    output logic [1:0]       pll_phasesel,
    output logic             pll_phasedir,
    output logic             pll_phasestep,
    output logic             pll_phaseloadreg,
    output logic             pll_reset,
    input  logic             pll_locked
);

    localparam int MAX_A   = (SETUP_CYC > STEP_HIGH_CYC) ? SETUP_CYC : STEP_HIGH_CYC;
    localparam int MAX_B   = (SETTLE_CYC > RESET_CYC) ? SETTLE_CYC : RESET_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL = (MAX_C > LOCK_TIMEOUT) ? MAX_C : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(MAX_ALL) + 1;

    localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] HIGH_LAST   = TMR_W'(STEP_HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] RESET_LAST  = TMR_W'(RESET_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        PLL_RST,
        SETUP,
        STEP_HI,
        STEP_LO,
        WAIT_LOCK,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   remaining;
    logic [1:0]         sel_q;
    logic               dir_q;
    logic               err_q;
    logic               lock_meta;
    logic               locked_s;
    logic               accept;
    logic               timeout_hit;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Each timed state leaves when its timer reaches
    // the last cycle of its interval; the timer restarts on every entry.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_relock) begin
                        next_state = PLL_RST;
                    end else if (req_steps != '0) begin
                        next_state = SETUP;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            PLL_RST: begin
                if (timer == RESET_LAST) begin
                    next_state = WAIT_LOCK;
                end
            end
            SETUP: begin
                if (timer == SETUP_LAST) begin
                    next_state = STEP_HI;
                end
            end
            STEP_HI: begin
                if (timer == HIGH_LAST) begin
                    next_state = STEP_LO;
                end
            end
            STEP_LO: begin
                // remaining was already decremented when STEP_HI ended
                if (timer == SETTLE_LAST) begin
                    next_state = (remaining != '0) ? STEP_HI : WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Steps still pending here means this lock wait followed a relock
                if (locked_s) begin
                    next_state = (remaining != '0) ? SETUP : DONE;
                end else if (timer == LOCK_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Interval timer: cleared on every state change, frozen while idle.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= '0;
        end else if (state != IDLE) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Request registers and remaining-step counter. A lock timeout throws
    // away any steps that had not yet been issued.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sel_q     <= '0;
            dir_q     <= 1'b0;
            remaining <= '0;
        end else if (accept) begin
            sel_q     <= req_sel;
            dir_q     <= req_dir;
            remaining <= req_steps;
        end else if (state == STEP_HI && next_state == STEP_LO) begin
            remaining <= remaining - CNT_W'(1);
        end else if (timeout_hit) begin
            remaining <= '0;
        end
    end

    // Sticky timeout flag, cleared only when a new request is accepted.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    // Outputs decode straight from state so an async reset drops
    // phasestep and pll_reset without waiting for a clock.
    assign req_ready        = (state == IDLE);
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign pll_reset        = (state == PLL_RST);
    assign pll_phasestep    = (state == STEP_HI);
    assign pll_phaseloadreg = 1'b0;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign err_timeout      = err_q;

endmodule

// File: tb/tb_pll_phase_seq.sv
`timescale 1ns/1ps
// tb_pll_phase_seq
// Directed self-checking bench for pll_phase_seq. Cycle numbers in the
// checks count from the cycle following the accepting clock edge (c=1).
module tb_pll_phase_seq;

    logic       clk_i;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       req_relock;
    logic       done;
    logic       busy;
    logic       err_timeout;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir;
    logic       pll_phasestep;
    logic       pll_phaseloadreg;
    logic       pll_reset;
    logic       pll_locked;

    int n_cmp  = 0;
    int n_fail = 0;

    pll_phase_seq dut (
        .clk_i            (clk_i),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_sel          (req_sel),
        .req_dir          (req_dir),
        .req_steps        (req_steps),
        .req_relock       (req_relock),
        .done             (done),
        .busy             (busy),
        .err_timeout      (err_timeout),
        .pll_phasesel     (pll_phasesel),
        .pll_phasedir     (pll_phasedir),
        .pll_phasestep    (pll_phasestep),
        .pll_phaseloadreg (pll_phaseloadreg),
        .pll_reset        (pll_reset),
        .pll_locked       (pll_locked)
    );

    // 100 MHz clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for exactly one accepting edge (caller ensures idle).
    task automatic send(input logic [1:0] sel, input logic dir,
                        input logic [7:0] steps, input logic relock);
        req_sel    = sel;
        req_dir    = dir;
        req_steps  = steps;
        req_relock = relock;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        int pulses;
        int done_cyc;
        int done_cnt;
        logic prev_step;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        req_dir    = 1'b0;
        req_steps  = 8'd0;
        req_relock = 1'b0;
        pll_locked = 1'b1;

        // ---- reset values ----
        repeat (2) tick();
        check1("rst req_ready", req_ready, 1'b1);
        check1("rst busy", busy, 1'b0);
        check1("rst done", done, 1'b0);
        check1("rst err", err_timeout, 1'b0);
        check1("rst phasestep", pll_phasestep, 1'b0);
        check1("rst pll_reset", pll_reset, 1'b0);
        check32("rst phasesel", int'(pll_phasesel), 0);
        check1("rst phasedir", pll_phasedir, 1'b0);
        check1("rst loadreg", pll_phaseloadreg, 1'b0);
        @(negedge clk_i);
        reset_n = 1'b1;
        repeat (3) tick();

        // ---- 3 steps, sel=2, dir=1, locked ----
        send(2'd2, 1'b1, 8'd3, 1'b0);
        check32("t1 phasesel", int'(pll_phasesel), 2);
        check1("t1 phasedir", pll_phasedir, 1'b1);
        for (int c = 1; c <= 45; c++) begin
            check1($sformatf("t1 step c%0d", c), pll_phasestep,
                   (c >= 3 && c <= 6) || (c >= 15 && c <= 18) || (c >= 27 && c <= 30));
            check1($sformatf("t1 done c%0d", c), done, c == 40);
            check1($sformatf("t1 busy c%0d", c), busy, c <= 40);
            check1($sformatf("t1 rst c%0d", c), pll_reset, 1'b0);
            tick();
        end

        // ---- async reset while in STEP_HI ----
        send(2'd1, 1'b0, 8'd5, 1'b0);
        tick();
        tick();
        check1("mid step before rst", pll_phasestep, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check1("mid step async", pll_phasestep, 1'b0);
        check1("mid busy async", busy, 1'b0);
        check1("mid pll_reset async", pll_reset, 1'b0);
        @(negedge clk_i);
        reset_n = 1'b1;
        tick();
        check1("mid req_ready", req_ready, 1'b1);
        check1("mid busy", busy, 1'b0);
        check1("mid err", err_timeout, 1'b0);
        check1("mid done", done, 1'b0);
        check32("mid phasesel", int'(pll_phasesel), 0);
        repeat (3) tick();

        // ---- zero steps, no relock ----
        send(2'd3, 1'b1, 8'd0, 1'b0);
        check1("z done c1", done, 1'b1);
        check1("z step c1", pll_phasestep, 1'b0);
        check1("z rst c1", pll_reset, 1'b0);
        tick();
        check1("z done c2", done, 1'b0);
        check1("z ready c2", req_ready, 1'b1);

        // ---- relock with 1 step, lock returns 5 cycles after reset falls ----
        send(2'd1, 1'b1, 8'd1, 1'b1);
        pll_locked = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 22) pll_locked = 1'b1;
            check1($sformatf("rl rst c%0d", c), pll_reset, c <= 16);
            check1($sformatf("rl step c%0d", c), pll_phasestep, c >= 27 && c <= 30);
            check1($sformatf("rl done c%0d", c), done, c == 40);
            tick();
        end
        check1("rl err", err_timeout, 1'b0);

        // ---- relock with 4 steps, lock never returns ----
        pll_locked = 1'b0;
        repeat (3) tick();
        send(2'd0, 1'b0, 8'd4, 1'b1);
        for (int c = 1; c <= 1020; c++) begin
            check1($sformatf("to rst c%0d", c), pll_reset, c <= 16);
            check1($sformatf("to step c%0d", c), pll_phasestep, 1'b0);
            check1($sformatf("to done c%0d", c), done, c == 1017);
            check1($sformatf("to err c%0d", c), err_timeout, c >= 1017);
            tick();
        end
        pll_locked = 1'b1;
        repeat (3) tick();
        check1("to err sticky", err_timeout, 1'b1);
        send(2'd0, 1'b0, 8'd0, 1'b0);
        check1("to err cleared", err_timeout, 1'b0);
        check1("to clear done", done, 1'b1);
        tick();

        // ---- req_valid held high, requests change while busy ----
        req_sel    = 2'd3;
        req_dir    = 1'b1;
        req_steps  = 8'd1;
        req_relock = 1'b0;
        req_valid  = 1'b1;
        check1("hs ready c0", req_ready, 1'b1);
        tick();
        for (int c = 1; c <= 37; c++) begin
            if (c == 1) begin
                req_sel   = 2'd1;
                req_dir   = 1'b0;
                req_steps = 8'd0;
            end
            if (c == 18) begin
                req_sel   = 2'd0;
                req_dir   = 1'b1;
                req_steps = 8'd1;
            end
            if (c == 20) req_valid = 1'b0;
            check1($sformatf("hs ready c%0d", c), req_ready,
                   c == 17 || c == 19 || c >= 36);
            check1($sformatf("hs done c%0d", c), done,
                   c == 16 || c == 18 || c == 35);
            check32($sformatf("hs sel c%0d", c), int'(pll_phasesel),
                    (c <= 17) ? 3 : (c <= 19) ? 1 : 0);
            check1($sformatf("hs dir c%0d", c), pll_phasedir,
                   (c <= 17) ? 1'b1 : (c <= 19) ? 1'b0 : 1'b1);
            check1($sformatf("hs step c%0d", c), pll_phasestep,
                   (c >= 3 && c <= 6) || (c >= 22 && c <= 25));
            tick();
        end

        // ---- full-range step count ----
        send(2'd2, 1'b0, 8'd255, 1'b0);
        pulses    = 0;
        done_cyc  = 0;
        done_cnt  = 0;
        prev_step = 1'b0;
        for (int c = 1; c <= 3070; c++) begin
            if (pll_phasestep && !prev_step) pulses++;
            prev_step = pll_phasestep;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            tick();
        end
        check32("max pulses", pulses, 255);
        check32("max done cycle", done_cyc, 3064);
        check32("max done count", done_cnt, 1);
        check1("max idle", req_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
